// File: rtl/key_entry_controller.sv
// Keypad entry sequencer: collects BCD digits from PS/2 keycodes and commits them as alarm or time.
// Optional macro AL_TIME_VALIDATE_EN: commits additionally require the low four digits to form a legal HHMM.
module key_entry_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int TIMEOUT_SECS = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    one_second,
    input  logic [7:0]              key,
    output logic [4*NUM_DIGITS-1:0] out_key_buffer,
    output logic [3:0]              digit_count,
    output logic                    load_alarm,
    output logic                    load_new_time,
    output logic                    show_alarm,
    output logic                    out_show_keyboard,
    output logic                    entry_error,
    output logic [3:0]              debug_state_out
);
    // state         | meaning
    // SHOW_TIME     | idle, buffer cleared
    // KEY_STORE     | shift digit in / backspace out
    // KEY_HOLD      | wait for key release code
    // KEY_RELEASE   | wait for key line to go invalid
    // KEY_ENTRY     | waiting for next key, timeout running
    // COMMIT_ALARM  | load_alarm pulse
    // COMMIT_TIME   | load_new_time pulse
    // SHOW_ALARM    | alarm displayed while key held
    // ALARM_RELEASE | wait for key line to go invalid
    // ERROR         | entry_error pulse
    localparam int W = 4 * NUM_DIGITS;

    localparam logic [3:0] S_SHOW_TIME     = 4'd0;
    localparam logic [3:0] S_KEY_STORE     = 4'd1;
    localparam logic [3:0] S_KEY_HOLD      = 4'd2;
    localparam logic [3:0] S_KEY_RELEASE   = 4'd3;
    localparam logic [3:0] S_KEY_ENTRY     = 4'd4;
    localparam logic [3:0] S_COMMIT_ALARM  = 4'd5;
    localparam logic [3:0] S_COMMIT_TIME   = 4'd6;
    localparam logic [3:0] S_SHOW_ALARM    = 4'd7;
    localparam logic [3:0] S_ALARM_RELEASE = 4'd8;
    localparam logic [3:0] S_ERROR         = 4'd9;

    localparam logic [7:0] KP_0            = 8'h70;
    localparam logic [7:0] KP_1            = 8'h69;
    localparam logic [7:0] KP_2            = 8'h72;
    localparam logic [7:0] KP_3            = 8'h7A;
    localparam logic [7:0] KP_4            = 8'h6B;
    localparam logic [7:0] KP_5            = 8'h73;
    localparam logic [7:0] KP_6            = 8'h74;
    localparam logic [7:0] KP_7            = 8'h6C;
    localparam logic [7:0] KP_8            = 8'h75;
    localparam logic [7:0] KP_9            = 8'h7D;
    localparam logic [7:0] KP_STAR         = 8'h7C;
    localparam logic [7:0] KP_MINUS        = 8'h7B;
    localparam logic [7:0] KP_PLUS         = 8'h79;
    localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;
    localparam logic [7:0] KP_INVALID      = 8'hFF;

    logic [3:0]   r_state;
    logic [3:0]   w_next;
    logic [W-1:0] r_buf;
    logic [3:0]   r_cnt;
    logic [7:0]   r_timer;
    logic [3:0]   r_store_digit;
    logic         r_store_bksp;
    logic         r_load_alarm;
    logic         r_load_new_time;
    logic         r_show_alarm;
    logic         r_show_kb;
    logic         r_entry_error;

    logic         w_key_is_digit;
    logic [3:0]   w_key_digit;
    logic         w_full;
    logic         w_time_ok;
    logic         w_reload;
    logic         w_count_en;

    always_comb begin
        w_key_is_digit = 1'b1;
        w_key_digit    = 4'd0;
        case (key)
            KP_0:    w_key_digit = 4'd0;
            KP_1:    w_key_digit = 4'd1;
            KP_2:    w_key_digit = 4'd2;
            KP_3:    w_key_digit = 4'd3;
            KP_4:    w_key_digit = 4'd4;
            KP_5:    w_key_digit = 4'd5;
            KP_6:    w_key_digit = 4'd6;
            KP_7:    w_key_digit = 4'd7;
            KP_8:    w_key_digit = 4'd8;
            KP_9:    w_key_digit = 4'd9;
            default: w_key_is_digit = 1'b0;
        endcase
    end

    assign w_full = (r_cnt == 4'(NUM_DIGITS));

`ifdef AL_TIME_VALIDATE_EN
    logic [15:0] w_low16;
    if (NUM_DIGITS >= 4) begin : g_low_direct
        assign w_low16 = r_buf[15:0];
    end else begin : g_low_padded
        assign w_low16 = 16'(r_buf);
    end
    // HH <= 23 and MM <= 59, with every nibble a decimal digit
    assign w_time_ok = (w_low16[15:12] <= 4'd2) && (w_low16[11:8] <= 4'd9)
                    && (w_low16[7:4] <= 4'd5) && (w_low16[3:0] <= 4'd9)
                    && !((w_low16[15:12] == 4'd2) && (w_low16[11:8] > 4'd3));
`else
    assign w_time_ok = 1'b1;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_SHOW_TIME: begin
                if (key == KP_STAR)      w_next = S_SHOW_ALARM;
                else if (w_key_is_digit) w_next = S_KEY_STORE;
            end
            S_KEY_STORE:   w_next = S_KEY_HOLD;
            S_KEY_HOLD:    if (key == KP_KEY_RELEASED) w_next = S_KEY_RELEASE;
            S_KEY_RELEASE: if (key == KP_INVALID)      w_next = S_KEY_ENTRY;
            S_KEY_ENTRY: begin
                if (r_timer == 8'd0)     w_next = S_SHOW_TIME;
                else if (w_key_is_digit) w_next = S_KEY_STORE;
                else if (key == KP_PLUS) begin
                    if (r_cnt != 4'd0) w_next = S_KEY_STORE;
                end
                else if (key == KP_STAR)  w_next = (w_full && w_time_ok) ? S_COMMIT_ALARM : S_ERROR;
                else if (key == KP_MINUS) w_next = (w_full && w_time_ok) ? S_COMMIT_TIME : S_ERROR;
            end
            S_COMMIT_ALARM:  w_next = S_SHOW_TIME;
            S_COMMIT_TIME:   w_next = S_SHOW_TIME;
            S_SHOW_ALARM:    if (key == KP_KEY_RELEASED) w_next = S_ALARM_RELEASE;
            S_ALARM_RELEASE: if (key == KP_INVALID)      w_next = S_SHOW_TIME;
            S_ERROR:         w_next = S_KEY_HOLD;
            default:         w_next = S_SHOW_TIME;
        endcase
    end

    assign w_reload   = (r_state == S_KEY_STORE) || (r_state == S_ERROR)
                     || ((r_state == S_KEY_RELEASE) && (w_next == S_KEY_ENTRY));
    assign w_count_en = (r_state == S_KEY_HOLD) || (r_state == S_KEY_RELEASE)
                     || (r_state == S_KEY_ENTRY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_SHOW_TIME;
            r_buf           <= '0;
            r_cnt           <= 4'd0;
            r_timer         <= 8'd0;
            r_store_digit   <= 4'd0;
            r_store_bksp    <= 1'b0;
            r_load_alarm    <= 1'b0;
            r_load_new_time <= 1'b0;
            r_show_alarm    <= 1'b0;
            r_show_kb       <= 1'b0;
            r_entry_error   <= 1'b0;
        end else begin
            r_state <= w_next;

            // Capture the key as it enters KEY_STORE so a fast release cannot corrupt the store
            if (w_next == S_KEY_STORE) begin
                r_store_digit <= w_key_digit;
                r_store_bksp  <= (key == KP_PLUS);
            end

            if (w_next == S_SHOW_TIME) begin
                r_buf <= '0;
                r_cnt <= 4'd0;
            end else if (r_state == S_KEY_STORE) begin
                if (r_store_bksp) begin
                    r_buf <= {4'd0, r_buf[W-1:4]};
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_buf <= {r_buf[W-5:0], r_store_digit};
                    if (!w_full) r_cnt <= r_cnt + 4'd1;
                end
            end

            if (w_reload)
                r_timer <= 8'(TIMEOUT_SECS);
            else if (one_second && w_count_en && (r_timer != 8'd0))
                r_timer <= r_timer - 8'd1;

            r_load_alarm    <= (w_next == S_COMMIT_ALARM);
            r_load_new_time <= (w_next == S_COMMIT_TIME);
            r_entry_error   <= (w_next == S_ERROR);
            r_show_alarm    <= (w_next == S_SHOW_ALARM);
            r_show_kb       <= ((w_next >= S_KEY_STORE) && (w_next <= S_COMMIT_TIME))
                            || (w_next == S_ERROR);
        end
    end

    assign out_key_buffer    = r_buf;
    assign digit_count       = r_cnt;
    assign load_alarm        = r_load_alarm;
    assign load_new_time     = r_load_new_time;
    assign show_alarm        = r_show_alarm;
    assign out_show_keyboard = r_show_kb;
    assign entry_error       = r_entry_error;
    assign debug_state_out   = r_state;

endmodule

// File: doc/key_entry_controller.md
KEY_ENTRY_CONTROLLER -- requirements
Module: key_entry_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 4: BCD digits held in the entry buffer, legal range 2..8.
REQ-002 Parameter TIMEOUT_SECS, default 10: idle seconds before an entry is abandoned, legal range 1..255.
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port one_second, input, 1: one-clk-wide tick, once per second.
REQ-006 Port key, input, 8: PS/2 set-2 keycode level from keycodes.vh. KP_0..KP_9 are digits. KP_STAR (0x7C), KP_MINUS (0x7B), KP_PLUS (0x79), KP_KEY_RELEASED (0xF0) and KP_INVALID are also used.
REQ-007 Port out_key_buffer, output, 4*NUM_DIGITS: entered BCD digits, newest digit in bits [3:0].
REQ-008 Port digit_count, output, 4: number of valid digits entered, 0..NUM_DIGITS.
REQ-009 Port load_alarm, output, 1: one-cycle pulse that commits out_key_buffer as the alarm time.
REQ-010 Port load_new_time, output, 1: one-cycle pulse that commits out_key_buffer as the current time.
REQ-011 Port show_alarm, output, 1: level, display the alarm time.
REQ-012 Port out_show_keyboard, output, 1: level, display out_key_buffer.
REQ-013 Port entry_error, output, 1: one-cycle pulse, entry rejected.
REQ-014 Port debug_state_out, output, 4: current state encoding.

Function
REQ-015 All outputs are registered; every state change takes effect on the clk edge after the qualifying key value is sampled.
REQ-016 State encodings: SHOW_TIME=0, KEY_STORE=1, KEY_HOLD=2, KEY_RELEASE=3, KEY_ENTRY=4, COMMIT_ALARM=5, COMMIT_TIME=6, SHOW_ALARM=7, ALARM_RELEASE=8, ERROR=9.
REQ-017 Unused encodings return to SHOW_TIME on the next clk with all pulse outputs 0.
REQ-018 SHOW_TIME: buffer and digit_count are cleared; KP_STAR goes to SHOW_ALARM; a digit goes to KEY_STORE; any other key stays.
REQ-019 KEY_STORE (one cycle): buffer shifts left 4 bits and the new BCD digit enters [3:0]; digit_count increments, saturating at NUM_DIGITS so the oldest digit is discarded; timer loads TIMEOUT_SECS; next state is KEY_HOLD.
REQ-020 KEY_STORE with KP_PLUS (backspace): buffer shifts right 4 bits and zero-fills the top nibble; digit_count decrements; next state is KEY_HOLD.
REQ-021 KEY_HOLD: KP_KEY_RELEASED goes to KEY_RELEASE; otherwise stays, so one held press is stored exactly once.
REQ-022 KEY_RELEASE: KP_INVALID goes to KEY_ENTRY and reloads the timer; otherwise stays.
REQ-023 KEY_ENTRY: timer==0 goes to SHOW_TIME; else a digit goes to KEY_STORE; KP_PLUS with digit_count>0 goes to KEY_STORE (backspace); KP_PLUS with digit_count==0 stays.
REQ-024 KEY_ENTRY: KP_STAR goes to COMMIT_ALARM and KP_MINUS goes to COMMIT_TIME, but only if digit_count==NUM_DIGITS; otherwise either key goes to ERROR.
REQ-025 The timer decrements on one_second only in KEY_HOLD, KEY_RELEASE and KEY_ENTRY, and saturates at 0.
REQ-026 If one_second coincides with a timer reload, the reload wins.
REQ-027 COMMIT_ALARM and COMMIT_TIME: pulse load_alarm or load_new_time for exactly one cycle, then go to SHOW_TIME.
REQ-028 ERROR: pulse entry_error for one cycle; keep the buffer; reload the timer; go to KEY_HOLD, so the rejected key's release is consumed.
REQ-029 SHOW_ALARM: show_alarm=1 until KP_KEY_RELEASED, then go to ALARM_RELEASE.
REQ-030 ALARM_RELEASE: KP_INVALID goes to SHOW_TIME.
REQ-031 out_show_keyboard=1 in states 1-6 and 9; 0 otherwise.

Reset
REQ-032 reset_n low asynchronously forces SHOW_TIME, buffer=0, digit_count=0, timer=0 and all outputs 0, including during an entry.
REQ-033 Operation resumes on the first clk edge after reset_n deasserts.

Configuration
REQ-034 Macro AL_TIME_VALIDATE_EN defined: a commit also requires the low four digits to be a legal HHMM (HH≤23, MM≤59, every nibble ≤9); otherwise the commit goes to ERROR.
REQ-035 Macro AL_TIME_VALIDATE_EN undefined: any full entry is committed.

Verification
REQ-036 Scenario: keys 1,2,3,0 each press/release, then KP_STAR -> out_key_buffer=16'h1230 and load_alarm high for exactly one cycle.
REQ-037 Scenario: NUM_DIGITS=4, keys 1..5 -> buffer=16'h2345, digit_count=4; then KP_PLUS -> buffer=16'h0234, digit_count=3.
REQ-038 Scenario: keys 1,2 then KP_MINUS -> entry_error pulses once, no load pulse, buffer stays 16'h0012.
REQ-039 Scenario: one digit entered, then 10 one_second ticks with no key -> SHOW_TIME and buffer=0 after the 10th tick.
REQ-040 Scenario: with AL_TIME_VALIDATE_EN, 2,5,0,0 then KP_MINUS -> entry_error; without it -> load_new_time pulse.
REQ-041 Scenario: reset_n pulsed low while in KEY_HOLD -> every output 0 immediately, no clk edge needed.
